// File: rtl/dmni_hermes_rx_buffer.sv
// Credit-based receive FIFO between the Hermes router local port and the
// DMNI DMA. Each entry stores {eop, flit}. The block reports its occupancy
// and how many complete packets it holds, so DMA control can see that a
// whole packet is waiting before it starts a transfer.
module dmni_hermes_rx_buffer #(
  parameter int HERMES_FLIT_SIZE = 32,
  parameter int BUFFER_SIZE      = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              rx_i,
  input  logic                              eop_i,
  input  logic [HERMES_FLIT_SIZE-1:0]       data_i,
  output logic                              credit_o,
  output logic                              rx_o,
  output logic                              eop_o,
  output logic [HERMES_FLIT_SIZE-1:0]       data_o,
  input  logic                              credit_i,
  output logic [$clog2(BUFFER_SIZE):0]      occupancy_o,
  output logic [$clog2(BUFFER_SIZE):0]      pkt_count_o
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_SIZE);

  logic [HERMES_FLIT_SIZE:0] mem [BUFFER_SIZE];
  logic [PTR_W-1:0]          rd_ptr;
  logic [PTR_W-1:0]          wr_ptr;
  logic [CNT_W-1:0]          count;
  logic [CNT_W-1:0]          pkts;
  logic                      push;
  logic                      pop;
  logic                      push_eop;
  logic                      pop_eop;

  // Handshakes depend only on registered state, so credit_o never looks at
  // credit_i: a full buffer refuses a flit even when the head leaves that cycle.
  assign credit_o    = (count != FULL_CNT);
  assign rx_o        = (count != '0);
  assign push        = rx_i && credit_o;
  assign pop         = rx_o && credit_i;
  assign push_eop    = push && eop_i;
  assign pop_eop     = pop && eop_o;
  assign data_o      = mem[rd_ptr][HERMES_FLIT_SIZE-1:0];
  assign eop_o       = mem[rd_ptr][HERMES_FLIT_SIZE];
  assign occupancy_o = count;
  assign pkt_count_o = pkts;

  // Storage array: written on an accepted flit, never reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= {eop_i, data_i};
    end
  end

  // Pointers, occupancy and packet count; reset wins over push/pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      pkts   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      case ({push_eop, pop_eop})
        2'b10:   pkts <= pkts + CNT_W'(1);
        2'b01:   pkts <= pkts - CNT_W'(1);
        default: pkts <= pkts;
      endcase
    end
  end

endmodule

// File: doc/dmni_hermes_rx_buffer.md
Name: dmni_hermes_rx_buffer

Overview:
- Credit-based flit FIFO between the Hermes router local output port and the DMNI DMA receive interface.
- Decouples the router from DMA stalls. These include arbitration toward send, the wait for software to program the receive size/address, and memory contention.
- Carries end-of-packet alongside each flit.
- Reports buffer occupancy and the number of complete packets held, so software/DMA control can tell that a whole packet is waiting.

Parameters:
- HERMES_FLIT_SIZE, 32, flit data width in bits.
- BUFFER_SIZE, 8, FIFO depth in flits. Must be a power of two and at least 2. Pointer width is log2(BUFFER_SIZE).

Ports:
- clk_i  input  1  clock; all logic on rising edge
- rst_i  input  1  reset, synchronous, active-high
- rx_i  input  1  router presents a flit
- eop_i  input  1  presented flit is the last of its packet
- data_i  input  HERMES_FLIT_SIZE  presented flit
- credit_o  output  1  buffer can accept a flit this cycle
- rx_o  output  1  buffer presents a flit to the DMA
- eop_o  output  1  presented flit is end-of-packet
- data_o  output  HERMES_FLIT_SIZE  head flit
- credit_i  input  1  DMA accepts the presented flit this cycle
- occupancy_o  output  log2(BUFFER_SIZE)+1  flits currently stored
- pkt_count_o  output  log2(BUFFER_SIZE)+1  stored flits with eop set (complete packets fully in buffer)

Behaviour:
- Storage: BUFFER_SIZE entries of {eop, data}. Read pointer, write pointer and count are registers.
- Push: occurs on a cycle where rx_i && credit_o. Writes {eop_i, data_i} at the write pointer. Write pointer +1, wrapping modulo BUFFER_SIZE.
- Pop: occurs on a cycle where rx_o && credit_i. Read pointer +1, wrapping modulo BUFFER_SIZE.
- credit_o = (occupancy_o != BUFFER_SIZE). It is combinational from the count register, with no dependence on credit_i. This gives no same-cycle push-while-full, even when a pop happens in that cycle.
- rx_o = (occupancy_o != 0). data_o and eop_o are the entry at the read pointer.
  - When empty, rx_o = 0 and data_o/eop_o are don't-care. The bench must not check them.
- Latency: a flit pushed in cycle N is visible on rx_o/data_o in cycle N+1. There is no fall-through bypass.
- Occupancy update:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged, and both pointers advance.
- pkt_count_o update:
  - +1 on a push with eop_i = 1
  - -1 on a pop with eop_o = 1
  - both in the same cycle: unchanged.
- Invariant: pkt_count_o <= occupancy_o.
- Holding: while rx_o = 1 and credit_i = 0, data_o/eop_o stay stable. The head entry is never overwritten while stored.
- rx_i while credit_o = 0 is legal Hermes back-pressure. The router holds the flit; nothing is written and nothing is flagged.
- Full: occupancy_o = BUFFER_SIZE means credit_o = 0. A pop in that cycle raises credit_o in the next cycle.
- Empty: a credit_i-only cycle has no effect.
- Wrap-around: continuous streaming beyond BUFFER_SIZE flits preserves order with no loss or duplication.
- Reset (rst_i = 1 at a clock edge, including mid-packet):
  - pointers, occupancy_o and pkt_count_o = 0
  - credit_o = 1, rx_o = 0
  - stored flits are discarded
  - rst_i has priority over any simultaneous push/pop.
- Storage array needs no reset.
- Outputs derive only from registers, so they are glitch-free relative to clk_i.

Test Plan:
- Reset, then idle: after rst_i, credit_o = 1, rx_o = 0, occupancy_o = 0, pkt_count_o = 0. These must hold for 10 idle cycles.
- Single packet with DMA stalled (credit_i = 0), BUFFER_SIZE = 8:
  - Push 0xA0000001, 0x00000003, then 0x11, 0x22, 0x33 with eop on 0x33.
  - Required: occupancy_o = 5, pkt_count_o = 1, data_o = 0xA0000001.
  - Then assert credit_i for 5 cycles: flits come out in order, eop_o only with 0x33, counts return to 0.
- Fill to full:
  - Push 9 flits 0x0..0x8 with rx_i held high and credit_i = 0.
  - Required: credit_o drops after the 8th push, occupancy_o = 8, flit 0x8 not accepted.
  - One pop (0x0) raises credit_o the next cycle, and 0x8 is then accepted.
- Simultaneous push/pop: at occupancy 3, push and pop every cycle for 20 cycles with eop every 4th flit.
  - Required: occupancy_o stays 3, pointers wrap at least twice, and the output sequence equals the input sequence.
  - pkt_count_o changes only when a pushed eop and a popped eop do not coincide.
- Reset mid-packet: push 4 flits of an unfinished packet, pulse rst_i one cycle.
  - Required: occupancy_o = 0, rx_o = 0, credit_o = 1.
  - A new 2-flit packet 0xB0, 0xB1 (eop) then emerges alone, with pkt_count_o = 1 before it is drained.
